// File: rtl/ternary_sampler_if.sv
// Byte-stream in / ternary-polynomial out handshake bundle
// for ternary_sampler.
interface ternary_sampler_if #(
    parameter int N_COEF = 700,
    parameter int LANES  = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*LANES-1:0]    in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*N_COEF-1:0]   out_poly;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_poly
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_poly
    );
endinterface

// File: rtl/ternary_sampler.sv
// Mod-3 ternary polynomial sampler, LANES bytes per beat.
// TERNARY_PLUS_EN adds the HRSS ternary-plus sign fix.
module ternary_sampler #(
    parameter int N_COEF = 700,
    parameter int LANES  = 1
) (
    input logic              clk,
    input logic              rst,
    ternary_sampler_if.slave bus
);
    localparam int CNT_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_COEF - LANES);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(LANES);

`ifdef TERNARY_PLUS_EN
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIX     = 2'd1,
        DONE    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd2
    } state_t;
`endif

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                out_valid;
    logic [2*N_COEF-1:0] out_poly;
    logic                ready;
    logic                accept;
    logic [2*LANES-1:0]  codes;

    // Remainder 2 is already the -1 code.
    function automatic logic [1:0] enc(input logic [7:0] b);
        logic [7:0] r;
        r = b % 8'd3;
        return r[1:0];
    endfunction

    assign ready  = (state == COLLECT) && !rst;
    assign accept = bus.in_valid && ready;

    always_comb begin
        codes = '0;
        for (int k = 0; k < LANES; k++)
            codes[2*k +: 2] = enc(bus.in_data[8*k +: 8]);
    end

`ifdef TERNARY_PLUS_EN
    localparam int CW = $clog2(N_COEF) + 1;

    logic signed [CW-1:0] corr;
    logic signed [CW-1:0] delta;
    logic [1:0]           prev;

    function automatic logic signed [1:0] prod(
        input logic [1:0] a,
        input logic [1:0] b
    );
        if (a == 2'b00 || b == 2'b00)
            return 2'sd0;
        else if (a == b)
            return 2'sd1;
        else
            return -2'sd1;
    endfunction

    // prev carries the last coefficient of the previous beat.
    always_comb begin
        delta = '0;
        if (cnt != '0)
            delta = delta + CW'(prod(prev, codes[1:0]));
        for (int k = 1; k < LANES; k++)
            delta = delta
                  + CW'(prod(codes[2*k-2 +: 2], codes[2*k +: 2]));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_poly  <= '0;
`ifdef TERNARY_PLUS_EN
            corr      <= '0;
            prev      <= 2'b00;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        out_poly[2*int'(cnt) +: 2*LANES] <= codes;
`ifdef TERNARY_PLUS_EN
                        corr <= corr + delta;
                        prev <= codes[2*LANES-1 -: 2];
`endif
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef TERNARY_PLUS_EN
                            state <= FIX;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + STEP;
                        end
                    end
                end
`ifdef TERNARY_PLUS_EN
                FIX: begin
                    if (corr < 0) begin
                        for (int i = 0; i < N_COEF; i += 2)
                            out_poly[2*i +: 2] <=
                                {out_poly[2*i], out_poly[2*i+1]};
                    end
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
`ifdef TERNARY_PLUS_EN
                        corr      <= '0;
`endif
                    end
                end
                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid;
    assign bus.out_poly  = out_poly;
endmodule

// File: tb/tb_ternary_sampler.sv
// Directed bench for ternary_sampler: N_COEF=8 with
// LANES=1 and LANES=4 instances side by side.
module tb_ternary_sampler;
    localparam int N = 8;
`ifdef TERNARY_PLUS_EN
    localparam int          LAT   = 2;
    localparam logic [15:0] EXP_A = 16'h5814;
    localparam logic [15:0] EXP_B = 16'h14A1;
`else
    localparam int          LAT   = 1;
    localparam logic [15:0] EXP_A = 16'h6824;
    localparam logic [15:0] EXP_B = 16'h2492;
`endif
    localparam logic [15:0] EXP_1 = 16'h5555;
    localparam logic [63:0] VEC_A = 64'h0480FEFF_03020100;
    localparam logic [63:0] VEC_B = 64'h0C0B0A09_08070605;
    localparam logic [63:0] VEC_1 = 64'h01010101_01010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    ternary_sampler_if #(.N_COEF(N), .LANES(1)) b1 ();
    ternary_sampler_if #(.N_COEF(N), .LANES(4)) b4 ();

    ternary_sampler #(.N_COEF(N), .LANES(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );
    ternary_sampler #(.N_COEF(N), .LANES(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic feed(input bit wide, input logic [63:0] bytes,
                        input int nb, input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < nb && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(2) == 0) begin
                b1.in_valid = 1'b0;
                b4.in_valid = 1'b0;
            end else if (wide) begin
                b4.in_valid = 1'b1;
                b4.in_data  = bytes[32*i +: 32];
                if (b4.in_ready) i++;
            end else begin
                b1.in_valid = 1'b1;
                b1.in_data  = bytes[8*i +: 8];
                if (b1.in_ready) i++;
            end
        end
        chk("feed_beats", i, nb);
    endtask

    task automatic wait_out(input bit wide, input logic [15:0] exp,
                            input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            b1.in_valid = 1'b0;
            b4.in_valid = 1'b0;
            lat++;
        end while (!(wide ? b4.out_valid : b1.out_valid) && lat < 10);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_poly"}, wide ? b4.out_poly : b1.out_poly, exp);
    endtask

    task automatic take(input bit wide, input string tag);
        if (wide) b4.out_ready = 1'b1;
        else      b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        b4.out_ready = 1'b0;
        chk({tag, "_ov0"}, wide ? b4.out_valid : b1.out_valid, 0);
        chk({tag, "_ir1"}, wide ? b4.in_ready : b1.in_ready, 1);
    endtask

    initial begin
        b1.in_valid  = 1'b0;
        b1.in_data   = '0;
        b1.out_ready = 1'b0;
        b4.in_valid  = 1'b0;
        b4.in_data   = '0;
        b4.out_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ir1", b1.in_ready, 0);
        chk("rst_ir4", b4.in_ready, 0);
        chk("rst_ov1", b1.out_valid, 0);
        chk("rst_poly1", b1.out_poly, 0);
        chk("rst_poly4", b4.out_poly, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ir1", b1.in_ready, 1);

        feed(0, VEC_A, 8, 0);
        wait_out(0, EXP_A, "a1");
        take(0, "a1");

        // out_ready with nothing to offer must be harmless
        b4.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        b4.out_ready = 1'b0;
        chk("idle_rdy_ov4", b4.out_valid, 0);
        chk("idle_rdy_ir4", b4.in_ready, 1);

        feed(1, VEC_A, 2, 0);
        wait_out(1, EXP_A, "a4");
        take(1, "a4");

        feed(0, VEC_1, 8, 0);
        wait_out(0, EXP_1, "ones1");
        take(0, "ones1");

        feed(1, VEC_1, 2, 0);
        wait_out(1, EXP_1, "ones4");
        take(1, "ones4");

        feed(0, VEC_B, 8, 1);
        wait_out(0, EXP_B, "bp1");
        b1.in_valid = 1'b1;
        b1.in_data  = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_poly", b1.out_poly, EXP_B);
            chk("hold_ir", b1.in_ready, 0);
            chk("hold_ov", b1.out_valid, 1);
        end
        b1.in_valid = 1'b0;
        take(0, "bp1");

        feed(0, VEC_A, 8, 1);
        wait_out(0, EXP_A, "bp2");
        take(0, "bp2");

        feed(1, VEC_B, 2, 1);
        wait_out(1, EXP_B, "bp4");
        take(1, "bp4");

        feed(0, VEC_B, 3, 0);
        @(negedge clk);
        b1.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ov", b1.out_valid, 0);
        chk("midrst_poly", b1.out_poly, 0);
        rst = 1'b0;

        feed(0, VEC_A, 8, 0);
        wait_out(0, EXP_A, "fresh");
        take(0, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
